// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader
//
// Read-side drain engine for a synchronous FIFO. It issues FIFO reads
// against the empty flag. A 2-entry skid buffer absorbs the FIFO's
// one-cycle registered read latency. Words are presented on a
// valid/ready stream that supports full backpressure. With a consumer
// that never stalls, the block sustains one word per cycle.
//
// Parameters:
//   WIDTH       data width, must match the FIFO dout width
//   CNT_W       width of the delivered-word counter
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   en          read enable; when low, no new FIFO reads are issued
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en  FIFO read strobe (combinational)
//   m_data      output word (head of the skid buffer)
//   m_valid     output word valid
//   m_ready     consumer accepts the word
//   word_count  number of delivered words (handshakes), wraps

module sync_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] word_count
);

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic             pop;
  logic [1:0]       level;
  logic [1:0]       level_after;

  // Stream side and read throttle.
  // "level" counts words held plus the word already requested from the FIFO.
  // "level_after" also subtracts this cycle's pop.
  // A new read is issued only while level_after stays below 2, so the
  // requested word always has a free slot when it arrives.
  // Subtracting the pop lets the first accept after a stall re-enable reads
  // in the same cycle.
  // level_after is also the next occupancy: every in-flight word is captured
  // this edge and every pop frees a slot.
  always_comb begin
    m_valid     = (occ_q != 2'd0);
    m_data      = buf_q[head_q];
    pop         = m_valid && m_ready;
    level       = occ_q + {1'b0, inflight_q};
    level_after = level - {1'b0, pop};
    fifo_rd_en  = !rst && en && !fifo_empty && (level_after < 2'd2);
  end

  // Next-state computation for the skid buffer.
  // The capture and the pop use separate pointers, so both may happen in the
  // same cycle; occupancy then stays put while both pointers advance.
  always_comb begin
    buf_d        = buf_q;
    tail_d       = tail_q;
    head_d       = head_q;
    word_count_d = word_count_q;
    occ_d        = level_after;
    inflight_d   = fifo_rd_en;
    if (inflight_q) begin
      buf_d[tail_q] = fifo_dout;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d       = ~head_q;
      word_count_d = word_count_q + CNT_W'(1);
    end
  end

  // Control state, cleared by reset.
  // Buffered and in-flight words are discarded on reset. The FIFO is reset
  // alongside this block, so no re-read is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      word_count_q <= word_count_d;
    end
  end

  // Buffer storage carries no reset.
  // Its contents only matter when occupancy says so.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign word_count = word_count_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader
//
// Directed bench for sync_fifo_reader.
// A small behavioural FIFO with a one-cycle registered read feeds the DUT.
// A negedge monitor records delivered words and FIFO read pulses.
// Each scenario task drives stimulus at #1 after the rising edge and samples
// at the falling edge, comparing against hand-computed expected values.
// The counter is built with CNT_W = 4 so that wrap-around is reachable.

module tb_sync_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] word_count;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO storage.
  // wr_ptr is owned by the stimulus tasks; rd_ptr is owned by the read process.
  logic [7:0] mem [128];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  // Monitor state, owned by the negedge monitor.
  logic [7:0] got [128];
  int         n_got = 0;
  int         rd_pulses = 0;
  logic       underflow_seen = 1'b0;
  logic       occ_bad_seen = 1'b0;

  sync_fifo_reader #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port with registered dout.
  // Reset flushes everything written so far, mirroring a system in which the
  // FIFO and the reader are reset together.
  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_dout <= mem[rd_ptr % 128];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Mid-cycle monitor.
  // It logs every handshake and read pulse.
  // It also latches any underflow read or illegal occupancy so the scenarios
  // can check them.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
      if (fifo_rd_en && fifo_empty) underflow_seen <= 1'b1;
      if (dut.occ_q > 2'd2) occ_bad_seen <= 1'b1;
      if (m_valid && m_ready) begin
        got[n_got % 128] <= m_data;
        n_got            <= n_got + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] v);
    mem[wr_ptr % 128] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Reset gates the read strobe even with a non-empty FIFO, and clears the outputs.
  task automatic test_reset();
    rst = 1'b1;
    push_word(8'hEE);
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_rd_en_gated got=%b want=0", fifo_rd_en);
    end
    step();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_m_valid got=%b want=0", m_valid);
    end
    checks++;
    if (word_count !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_word_count got=%0d want=0", word_count);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release_idle got rd=%b valid=%b want 0 0", fifo_rd_en, m_valid);
    end
    step();
  endtask

  // One word: the read is issued in cycle 0 and the word is valid in cycle 2.
  task automatic test_single_word();
    logic [4:0] exp_rd;
    logic [4:0] exp_v;
    exp_rd = 5'b00001;
    exp_v  = 5'b00100;
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    push_word(8'hA5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== exp_rd[c]) begin
        errors++; $display("[TB] FAIL single_rd_en cycle=%0d got=%b want=%b", c, fifo_rd_en, exp_rd[c]);
      end
      checks++;
      if (m_valid !== exp_v[c]) begin
        errors++; $display("[TB] FAIL single_m_valid cycle=%0d got=%b want=%b", c, m_valid, exp_v[c]);
      end
      if (c == 2) begin
        checks++;
        if (m_data !== 8'hA5) begin
          errors++; $display("[TB] FAIL single_m_data got=%h want=a5", m_data);
        end
      end
      step();
    end
    checks++;
    if (word_count !== 4'd1) begin
      errors++; $display("[TB] FAIL single_word_count got=%0d want=1", word_count);
    end
  endtask

  // Four words back to back: reads in cycles 0..3 and valid words in cycles 2..5.
  task automatic test_burst();
    logic [7:0] exp_rd;
    logic [7:0] exp_v;
    exp_rd = 8'b00001111;
    exp_v  = 8'b00111100;
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== exp_rd[c]) begin
        errors++; $display("[TB] FAIL burst_rd_en cycle=%0d got=%b want=%b", c, fifo_rd_en, exp_rd[c]);
      end
      checks++;
      if (m_valid !== exp_v[c]) begin
        errors++; $display("[TB] FAIL burst_m_valid cycle=%0d got=%b want=%b", c, m_valid, exp_v[c]);
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (m_data !== 8'(c - 1)) begin
          errors++; $display("[TB] FAIL burst_m_data cycle=%0d got=%h want=%h", c, m_data, 8'(c - 1));
        end
      end
      step();
    end
    checks++;
    if (word_count !== 4'd4) begin
      errors++; $display("[TB] FAIL burst_word_count got=%0d want=4", word_count);
    end
  endtask

  // Stall for 10 cycles: only two reads go out, and the head word holds steady.
  // On release, all six words drain in order.
  task automatic test_backpressure();
    int p0;
    int n0;
    do_reset();
    en = 1'b1;
    m_ready = 1'b0;
    p0 = rd_pulses;
    n0 = n_got;
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01) begin
          errors++; $display("[TB] FAIL stall_hold cycle=%0d got valid=%b data=%h want 1 01", c, m_valid, m_data);
        end
      end
      step();
    end
    checks++;
    if (rd_pulses - p0 != 2) begin
      errors++; $display("[TB] FAIL stall_rd_pulses got=%0d want=2", rd_pulses - p0);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (n_got - n0 != 6) begin
      errors++; $display("[TB] FAIL stall_delivered got=%0d want=6", n_got - n0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[(n0 + i) % 128] !== 8'(i + 1)) begin
        errors++; $display("[TB] FAIL stall_order idx=%0d got=%h want=%h", i, got[(n0 + i) % 128], 8'(i + 1));
      end
    end
    checks++;
    if (word_count !== 4'd6) begin
      errors++; $display("[TB] FAIL stall_word_count got=%0d want=6", word_count);
    end
  endtask

  // en drops right after a read is issued.
  // That word still arrives, and nothing more is read until en returns.
  task automatic test_enable_gating();
    int p0;
    int n0;
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    p0 = rd_pulses;
    n0 = n_got;
    push_word(8'h30);
    push_word(8'h31);
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++; $display("[TB] FAIL en_first_read got=%b want=1", fifo_rd_en);
    end
    step();
    en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0) begin
        errors++; $display("[TB] FAIL en_low_no_read cycle=%0d got=%b want=0", c, fifo_rd_en);
      end
      step();
    end
    checks++;
    if (rd_pulses - p0 != 1 || n_got - n0 != 1) begin
      errors++; $display("[TB] FAIL en_low_counts got reads=%0d words=%0d want 1 1", rd_pulses - p0, n_got - n0);
    end
    checks++;
    if (got[n0 % 128] !== 8'h30) begin
      errors++; $display("[TB] FAIL en_inflight_word got=%h want=30", got[n0 % 128]);
    end
    en = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (n_got - n0 != 2 || got[(n0 + 1) % 128] !== 8'h31) begin
      errors++; $display("[TB] FAIL en_resume got words=%0d data=%h want 2 31", n_got - n0, got[(n0 + 1) % 128]);
    end
    checks++;
    if (word_count !== 4'd2) begin
      errors++; $display("[TB] FAIL en_word_count got=%0d want=2", word_count);
    end
  endtask

  // Reset while stalled at full capacity: one word is buffered and the next
  // is in flight. Everything is dropped, the count clears, and fresh words
  // flow correctly afterwards. word_count enters this test non-zero.
  task automatic test_reset_midflight();
    int n0;
    en = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h20 + i));
    step();
    step();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || fifo_rd_en !== 1'b0 || m_data !== 8'h20) begin
      errors++; $display("[TB] FAIL mid_full_state got valid=%b rd=%b data=%h want 1 0 20", m_valid, fifo_rd_en, m_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_after_reset got valid=%b rd=%b want 0 0", m_valid, fifo_rd_en);
    end
    checks++;
    if (word_count !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_word_count_clear got=%0d want=0", word_count);
    end
    step();
    n0 = n_got;
    m_ready = 1'b1;
    push_word(8'h10);
    push_word(8'h11);
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (n_got - n0 != 2) begin
      errors++; $display("[TB] FAIL mid_fresh_count got=%0d want=2", n_got - n0);
    end
    checks++;
    if (got[n0 % 128] !== 8'h10 || got[(n0 + 1) % 128] !== 8'h11) begin
      errors++; $display("[TB] FAIL mid_fresh_data got=%h %h want 10 11", got[n0 % 128], got[(n0 + 1) % 128]);
    end
    checks++;
    if (word_count !== 4'd2) begin
      errors++; $display("[TB] FAIL mid_word_count got=%0d want=2", word_count);
    end
  endtask

  // Seventeen words through a 4-bit counter: the count wraps to 1.
  // The whole run must show no underflow read and no illegal occupancy.
  task automatic test_counter_wrap();
    int n0;
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    n0 = n_got;
    for (int i = 0; i < 17; i++) push_word(8'(8'h40 + i));
    for (int c = 0; c < 25; c++) step();
    checks++;
    if (n_got - n0 != 17) begin
      errors++; $display("[TB] FAIL wrap_delivered got=%0d want=17", n_got - n0);
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (got[(n0 + i) % 128] !== 8'(8'h40 + i)) begin
        errors++; $display("[TB] FAIL wrap_order idx=%0d got=%h want=%h", i, got[(n0 + i) % 128], 8'(8'h40 + i));
      end
    end
    checks++;
    if (word_count !== 4'd1) begin
      errors++; $display("[TB] FAIL wrap_word_count got=%0d want=1", word_count);
    end
    checks++;
    if (underflow_seen !== 1'b0) begin
      errors++; $display("[TB] FAIL underflow_read got=%b want=0", underflow_seen);
    end
    checks++;
    if (occ_bad_seen !== 1'b0) begin
      errors++; $display("[TB] FAIL occupancy_over_2 got=%b want=0", occ_bad_seen);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    step();
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_enable_gating();
    test_reset_midflight();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
